// File: rtl/cpu_step_controller_if.sv
// Board-side bundle for the CPU step controller.
// Contract: the core advances exactly one instruction per clk cycle in which
// cpu_en is high; all inputs are sampled on the rising clk edge; outputs are
// registered (halted/state decode the registered FSM state).
interface cpu_step_controller_if #(
    parameter int PC_WIDTH  = 32,
    parameter int DIV_WIDTH = 8
);
    logic                 CLK_BUTT;
    logic                 run_mode;
    logic [DIV_WIDTH-1:0] div;
    logic                 bp_en;
    logic [PC_WIDTH-1:0]  bp_addr;
    logic [PC_WIDTH-1:0]  pc;
    logic                 halt_clr;
    logic                 cpu_en;
    logic                 halted;
    logic [15:0]          step_count;
    logic [1:0]           state;

    // Board / core side: drives controls and PC, observes the enable.
    modport master (
        output CLK_BUTT, run_mode, div, bp_en, bp_addr, pc, halt_clr,
        input  cpu_en, halted, step_count, state
    );

    // Controller side.
    modport slave (
        input  CLK_BUTT, run_mode, div, bp_en, bp_addr, pc, halt_clr,
        output cpu_en, halted, step_count, state
    );
endinterface

// File: rtl/cpu_step_controller.sv
// Generates the RISC-V core clock-enable: single-step from a debounced push
// button, or free-run at one instruction every div+1 cycles with a PC
// breakpoint that parks the sequencer in HALT.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PC_WIDTH        = 32,
    parameter int DIV_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_step_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Counter compares against limit-1 so a limit of 1 toggles on the first differing edge.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Button path
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       db_level_q, db_level_d;
    logic       db_prev_q, db_prev_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       btn_rise;

    // Sequencer
    state_e               state_q, state_d;
    logic                 cpu_en_q, cpu_en_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 skip_q, skip_d;
    logic [15:0]          step_count_q, step_count_d;
    logic                 tick_due;
    logic                 bp_hit;

    // Synchroniser, debounce counter and rising-edge detect of the debounced level.
    always_comb begin
        sync1_d    = bus.CLK_BUTT;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        db_prev_d  = db_level_q;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
        btn_rise = db_level_q & ~db_prev_q;
    end

    // Next-state, enable, prescaler, skip flag and step counter.
    always_comb begin
        state_d      = state_q;
        cpu_en_d     = 1'b0;
        presc_d      = presc_q;
        skip_d       = skip_q;
        step_count_d = step_count_q;
        tick_due     = (presc_q == '0);
        bp_hit       = bus.bp_en && (bus.pc == bus.bp_addr) && !skip_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.run_mode) begin
                    state_d = ST_RUN;
                    presc_d = bus.div;
                end else if (btn_rise) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick_due) begin
                    presc_d = bus.div;
                    // A breakpoint on a due tick outranks leaving free-run.
                    if (bp_hit) begin
                        state_d = ST_HALT;
                    end else if (!bus.run_mode) begin
                        state_d = ST_IDLE;
                    end else begin
                        cpu_en_d = 1'b1;
                        skip_d   = 1'b0;
                    end
                end else begin
                    presc_d = presc_q - 1'b1;
                    if (!bus.run_mode) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                if (bus.halt_clr) begin
                    state_d = ST_IDLE;
                    skip_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cpu_en_d) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_level_q   <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= ST_IDLE;
            cpu_en_q     <= 1'b0;
            presc_q      <= '0;
            skip_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_level_q   <= db_level_d;
            db_prev_q    <= db_prev_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            presc_q      <= presc_d;
            skip_q       <= skip_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.step_count = step_count_q;
    assign bus.state      = state_q;

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
- Sequences the RISC-V core by generating its clock-enable (cpu_en) from the board clock, in one of two modes:
  - single-step: one instruction per debounced press of the CLK_BUTT push-button;
  - free-run: one instruction every DIV+1 cycles.
- Supports a PC breakpoint that halts free-run execution and keeps a 16-bit executed-step counter for the 16-bit result display.
- Sits between board I/O and the core; the core advances only in cycles where cpu_en=1.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before the debounced button level changes (range 1..255).
- PC_WIDTH, 32: width of the core PC and breakpoint address.
- DIV_WIDTH, 8: width of the free-run period field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- CLK_BUTT  in  1  raw asynchronous push-button, active-high.
- run_mode  in  1  0 = single-step, 1 = free-run.
- div  in  DIV_WIDTH  free-run period minus one.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_WIDTH  breakpoint PC.
- pc  in  PC_WIDTH  current core PC (PC of the next instruction to execute).
- halt_clr  in  1  one-cycle pulse that releases HALT.
- cpu_en  out  1  registered core clock-enable.
- halted  out  1  high while in HALT.
- step_count  out  16  number of cpu_en pulses issued.
- state  out  2  IDLE=0, RUN=1, HALT=2.

Behaviour:
- Reset (reset=0 at a clk edge), including mid-operation:
  - cpu_en=0, halted=0, step_count=0, state=IDLE;
  - sync flops, debounced level, debounce counter, prescaler and skip flag all cleared;
  - no pulse may leak out in the cycle after reset.
- Button path:
  - 2-flop synchroniser into sync2.
  - db_level toggles to sync2 after sync2 has differed from db_level on DEBOUNCE_CYCLES consecutive edges. Any match resets the counter.
  - btn_rise = db_level rising (one cycle).
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- IDLE:
  - run_mode=1 → RUN; the prescaler loads div.
  - Otherwise, btn_rise → cpu_en=1 on the next edge for exactly one cycle.
  - Breakpoint is ignored in single-step.
- RUN:
  - The prescaler decrements each cycle. When it reaches 0, a tick is due and the prescaler reloads div.
  - With div=0, ticks occur every cycle (cpu_en held high continuously).
  - A due tick asserts cpu_en on the next edge, unless bp_en=1, pc==bp_addr and skip=0. In that case → HALT, cpu_en=0, and no instruction is issued.
  - skip clears on the first issued tick.
  - run_mode=0 → IDLE on the next edge with cpu_en=0, even if a tick was due in that cycle.
  - btn_rise is ignored and dropped.
- HALT:
  - halted=1, cpu_en=0.
  - halt_clr=1 → IDLE, halted=0, skip=1, so the next RUN tick executes the breakpointed instruction.
  - run_mode changes and btn_rise are ignored while halted.
  - halt_clr outside HALT has no effect.
- step_count:
  - Increments on every edge where cpu_en is registered high.
  - Wraps 0xFFFF→0x0000.
- First RUN tick: if the state becomes RUN at edge T, the first cpu_en is high in the cycle after edge T+div+1.
- Simultaneous events:
  - reset dominates everything.
  - In RUN, the breakpoint takes priority over run_mode=0 only if both occur on a due tick. Otherwise run_mode=0 wins.

Test Plan:
- Step press (DEBOUNCE_CYCLES=4, run_mode=0): CLK_BUTT held high for 20 cycles → exactly one cpu_en cycle, 6 edges after the first edge sampling it high; step_count=1. Release and press again → step_count=2.
- Glitch reject: CLK_BUTT high for 3 cycles → cpu_en never asserted, step_count stays 0.
- Free-run rate: run_mode=1, div=3 for 40 cycles → cpu_en pulses spaced exactly 4 cycles apart, 10 pulses ±1. With div=0, cpu_en is continuously high.
- Breakpoint:
  - run_mode=1, div=1, bp_en=1, bp_addr=0x10, pc steps by 4 per cpu_en from 0 → halts with pc=0x10 unexecuted; halted=1, state=2, step_count=4.
  - halt_clr pulse → next tick executes (step_count=5) with no re-halt at 0x10.
- Wrap and mode exit: preload by running 65535 ticks, then one more → step_count=0x0000. Drop run_mode mid-prescale → state=0 next cycle, no extra cpu_en.
- Reset mid-run: reset=0 for one edge while cpu_en=1 → next cycle cpu_en=0, step_count=0, state=0, halted=0. Button presses during reset produce no pulse afterwards.
